// File: rtl/tnn_neuron_acc.sv
// ============================================================================
// Module   : tnn_neuron_acc
// Summary  : Multi-beat signed popcount accumulator with threshold activation.
//            When TNN_TERNARY_EN is defined, the activation is ternary; when it
//            is not defined, the activation is binary.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tnn_neuron_acc #(
    parameter int NBEATS = 4,
    parameter int ACC_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4:0]              pc_pos,
    input  logic [4:0]              pc_neg,
    input  logic signed [ACC_W-1:0] thr_hi,
    input  logic signed [ACC_W-1:0] thr_lo,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [1:0]              out_act,
    output logic signed [ACC_W-1:0] out_sum
);

    localparam int CNT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NBEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [CNT_W-1:0]          r_cnt;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [ACC_W-1:0]   r_thr_hi;
    logic                      r_out_valid;
    logic [1:0]                r_out_act;
    logic signed [ACC_W-1:0]   r_out_sum;

    logic                      w_accept;
    logic                      w_last;
    logic                      w_hs;
    logic signed [ACC_W-1:0]   w_diff;
    logic signed [ACC_W-1:0]   w_sum;
    logic signed [ACC_W-1:0]   w_thr_hi;
    logic [1:0]                w_act;

    assign in_ready = rst_n && (r_state != S_OUT);
    assign w_accept = in_valid && in_ready;
    // The counter is zero in IDLE, so one compare covers the NBEATS==1 case too.
    assign w_last   = w_accept && (r_cnt == C_LAST);
    assign w_hs     = (r_state == S_OUT) && out_ready;

    assign w_diff   = {{(ACC_W-5){1'b0}}, pc_pos} - {{(ACC_W-5){1'b0}}, pc_neg};
    assign w_sum    = ((r_state == S_IDLE) ? '0 : r_acc) + w_diff;
    // On a single-beat neuron the live thresholds have not been latched yet.
    assign w_thr_hi = (r_state == S_IDLE) ? thr_hi : r_thr_hi;

`ifdef TNN_TERNARY_EN
    logic signed [ACC_W-1:0]   r_thr_lo;
    logic signed [ACC_W-1:0]   w_thr_lo;

    assign w_thr_lo = (r_state == S_IDLE) ? thr_lo : r_thr_lo;
    assign w_act    = (w_sum > w_thr_hi) ? 2'b01 :
                      (w_sum < w_thr_lo) ? 2'b11 : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_thr_lo <= '0;
        end else if (w_accept && (r_state == S_IDLE) && !clear) begin
            r_thr_lo <= thr_lo;
        end
    end
`else
    logic w_unused_thr_lo;

    assign w_unused_thr_lo = ^thr_lo;
    assign w_act           = (w_sum > w_thr_hi) ? 2'b01 : 2'b00;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_accept) w_state_next = w_last ? S_OUT : S_ACC;
                S_ACC:   if (w_last)   w_state_next = S_OUT;
                S_OUT:   if (w_hs)     w_state_next = S_IDLE;
                default:               w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_acc       <= '0;
            r_thr_hi    <= '0;
            r_out_valid <= 1'b0;
            r_out_act   <= 2'b00;
            r_out_sum   <= '0;
        end else if (clear) begin
            r_cnt       <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_sum;
            r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
            if (r_state == S_IDLE) begin
                r_thr_hi <= thr_hi;
            end
            if (w_last) begin
                r_out_sum   <= w_sum;
                r_out_act   <= w_act;
                r_out_valid <= 1'b1;
            end
        end else if (w_hs) begin
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_act   = r_out_act;
    assign out_sum   = r_out_sum;

endmodule

`default_nettype wire

// File: tb/tb_tnn_neuron_acc.sv
// ============================================================================
// Module   : tb_tnn_neuron_acc
// Summary  : Scoreboard bench for tnn_neuron_acc (directed plus random neurons).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tnn_neuron_acc;

    localparam int NB = 4;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [4:0]    pc_pos = '0;
    logic [4:0]    pc_neg = '0;
    logic [AW-1:0] thr_hi = '0;
    logic [AW-1:0] thr_lo = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [1:0]    out_act;
    logic [AW-1:0] out_sum;

    tnn_neuron_acc #(.NBEATS(NB), .ACC_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pc_pos    (pc_pos),
        .pc_neg    (pc_neg),
        .thr_hi    (thr_hi),
        .thr_lo    (thr_lo),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_act   (out_act),
        .out_sum   (out_sum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    act;
        logic [AW-1:0] sum;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_cnt = 0;
    int   m_sum = 0;
    int   m_thi = 0;
    int   m_tlo = 0;
    bit   rand_rdy = 1'b0;

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int sv(input logic [AW-1:0] v);
        return int'($signed(v));
    endfunction

    // Reference: a neuron is NB accepted beats; sum of differences vs latched thresholds.
    task automatic model_accept(input int p, input int n, input logic [AW-1:0] th, input logic [AW-1:0] tl);
        exp_t e;
        if (m_cnt == 0) begin
            m_sum = 0;
            m_thi = sv(th);
            m_tlo = sv(tl);
        end
        m_sum += p - n;
        m_cnt++;
        if (m_cnt == NB) begin
            e.sum = AW'(m_sum);
`ifdef TNN_TERNARY_EN
            e.act = (m_sum > m_thi) ? 2'b01 : (m_sum < m_tlo) ? 2'b11 : 2'b00;
`else
            e.act = (m_sum > m_thi) ? 2'b01 : 2'b00;
`endif
            q.push_back(e);
            m_cnt = 0;
        end
    endtask

    task automatic model_flush();
        q.delete();
        m_cnt = 0;
        m_sum = 0;
    endtask

    task automatic beat(input int p, input int n, input logic [AW-1:0] th,
                        input logic [AW-1:0] tl, input bit clr);
        int tries = 0;
        bit acc   = 1'b0;
        do begin
            @(negedge clk);
            in_valid = 1'b1;
            pc_pos   = 5'(p);
            pc_neg   = 5'(n);
            thr_hi   = th;
            thr_lo   = tl;
            clear    = clr;
            #1;
            acc = in_ready && !clr;
            @(posedge clk);
            if (clr) model_flush();
            else if (acc) model_accept(p, n, th, tl);
            tries++;
        end while (!acc && !clr && tries < 64);
        if (!acc && !clr) begin
            checks++;
            errors++;
            $display("FAIL beat_accept_timeout actual=not_accepted expected=accepted at %0t", $time);
        end
    endtask

    task automatic idle(input int ncyc);
        repeat (ncyc) begin
            @(negedge clk);
            in_valid = 1'b0;
            clear    = 1'b0;
            @(posedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sum",   int'(out_sum),   0);
        chk("rst_out_act",   int'(out_act),   0);
        chk("rst_in_ready",  int'(in_ready),  0);
        model_flush();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: samples away from the rising edge, after the driver settles.
    bit            prev_hold = 1'b0;
    logic [1:0]    p_act;
    logic [AW-1:0] p_sum;
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (!rst_n) begin
            chk("rst_hold_valid", int'(out_valid), 0);
            chk("rst_hold_ready", int'(in_ready), 0);
            prev_hold = 1'b0;
        end else begin
            chk("out_valid_vs_model", int'(out_valid), int'(q.size() != 0));
            chk("in_ready_vs_model",  int'(in_ready),  int'(q.size() == 0));
            if (out_valid && prev_hold) begin
                chk("stall_act_stable", int'(out_act), int'(p_act));
                chk("stall_sum_stable", int'(out_sum), int'(p_sum));
            end
            if (out_valid && out_ready && !clear && q.size() != 0) begin
                e = q.pop_front();
                chk("out_act", int'(out_act), int'(e.act));
                chk("out_sum", sv(out_sum), sv(e.sum));
            end
            prev_hold = out_valid && !out_ready && !clear;
            p_act     = out_act;
            p_sum     = out_sum;
        end
    end

    always @(negedge clk) begin
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        do_reset();
        idle(1);

        // Mixed beats: 21+3-1+2 = 25 > 10
        out_ready = 1'b1;
        beat(21, 0, AW'(10), AW'(-10), 1'b0);
        beat(5,  2, AW'(10), AW'(-10), 1'b0);
        beat(0,  1, AW'(10), AW'(-10), 1'b0);
        beat(3,  1, AW'(10), AW'(-10), 1'b0);
        idle(2);

        // Most negative sum
        repeat (NB) beat(0, 21, AW'(10), AW'(-10), 1'b0);
        idle(2);

        // Sum equal to thr_hi; later threshold changes must be ignored
        beat(5, 0, AW'(10),  AW'(-10), 1'b0);
        beat(5, 0, AW'(-50), AW'(-10), 1'b0);
        beat(0, 0, AW'(-50), AW'(-10), 1'b0);
        beat(0, 0, AW'(-50), AW'(-10), 1'b0);
        idle(2);

        // Output stall with the next neuron's beats already presented
        out_ready = 1'b0;
        repeat (NB) beat(2, 0, AW'(5), AW'(-5), 1'b0);
        fork
            begin
                beat(9, 0, AW'(5), AW'(-5), 1'b0);
                beat(0, 3, AW'(5), AW'(-5), 1'b0);
                beat(1, 1, AW'(5), AW'(-5), 1'b0);
                beat(4, 0, AW'(5), AW'(-5), 1'b0);
            end
            begin
                repeat (6) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        idle(2);

        // Clear together with beat 3 drops the partial neuron
        beat(3, 0, AW'(0), AW'(-1), 1'b0);
        beat(3, 0, AW'(0), AW'(-1), 1'b0);
        beat(7, 0, AW'(0), AW'(-1), 1'b1);
        repeat (NB) beat(2, 1, AW'(0), AW'(-1), 1'b0);
        idle(2);

        // Reset after two beats, then a neuron with gaps in the middle
        beat(10, 0, AW'(3), AW'(-3), 1'b0);
        beat(10, 0, AW'(3), AW'(-3), 1'b0);
        do_reset();
        beat(1, 0, AW'(3), AW'(-3), 1'b0);
        idle(2);
        beat(1, 0, AW'(3), AW'(-3), 1'b0);
        idle(3);
        beat(1, 0, AW'(3), AW'(-3), 1'b0);
        beat(0, 0, AW'(3), AW'(-3), 1'b0);
        idle(3);

        // Random neurons, random back-pressure and occasional clears
        rand_rdy = 1'b1;
        for (int k = 0; k < 40; k++) begin
            for (int b = 0; b < NB; b++) begin
                int th;
                int tl;
                th = int'($urandom_range(0, 120)) - 60;
                tl = int'($urandom_range(0, 120)) - 60;
                beat(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                     AW'(th), AW'(tl), ($urandom_range(0, 24) == 0));
                if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            end
        end
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        for (int w = 0; w < 50 && q.size() != 0; w++) idle(1);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d pending expected=0 pending", q.size());
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
